// File: rtl/uart_tx_115200.sv
// uart_tx_115200: 8N1 UART transmitter (optional even parity) paced by a 16x oversample tick.
// tx is registered from the current state, so it follows every state change by one clk.
module uart_tx_115200 #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int PARITY_EN = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t          state, state_n;
    logic [4:0]      s, s_n;
    logic [2:0]      n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            p, p_n, done_n;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            p            <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            p            <= p_n;
            tx           <= (state == START) ? 1'b0 : (state == DATA) ? b[0] : (state == PARITY) ? p : 1'b1;
            tx_done_tick <= done_n;
        end
    end
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        p_n     = p;
        done_n  = 1'b0;
        case (state)
            IDLE:
                if (tx_start) begin
                    b_n     = din;
                    p_n     = ^din;
                    s_n     = '0;
                    state_n = START;
                end
            START:
                if (s_tick) begin
                    if (s == 5'd15) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = DATA;
                    end else s_n = s + 5'd1;
                end
            DATA:
                if (s_tick) begin
                    if (s == 5'd15) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == 3'(DBIT - 1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        else n_n = n + 3'd1;
                    end else s_n = s + 5'd1;
                end
            PARITY:
                if (s_tick) begin
                    if (s == 5'd15) begin
                        s_n     = '0;
                        state_n = STOP;
                    end else s_n = s + 5'd1;
                end
            STOP:
                if (s_tick) begin
                    if (s == 5'(SB_TICK - 1)) begin
                        s_n     = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else s_n = s + 5'd1;
                end
            default: state_n = IDLE;
        endcase
    end
    assign tx_busy = (state != IDLE);
endmodule
